// File: rtl/full_adder_pkg.sv
// Shared types and constants for the full_adder cell: truth table, default
// counter width and the sum/cout result struct.
package full_adder_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef struct packed {
        logic sum;
        logic cout;
    } fa_result_t;

    // {sum,cout} indexed by {a,b,cin}; entry 7 is the leftmost pair
    localparam logic [7:0][1:0] FA_TT = {2'b11, 2'b01, 2'b01, 2'b10,
                                         2'b01, 2'b10, 2'b10, 2'b00};

    function automatic fa_result_t fa_lookup(input logic [2:0] idx);
        return fa_result_t'(FA_TT[idx]);
    endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle of the full_adder cell; master drives operands,
// slave (the adder) drives combinational and registered results.
interface full_adder_if
    import full_adder_pkg::*;
    #(parameter int CNT_W = CNT_W_DEFAULT) ();

    logic             a;
    logic             b;
    logic             cin;
    logic             in_valid;
    logic             sum;
    logic             cout;
    logic             prop;
    logic             gen;
    logic             sum_q;
    logic             cout_q;
    logic             out_valid;
    logic [CNT_W-1:0] carry_cnt;
    logic             err_q;

    modport master (
        output a, b, cin, in_valid,
        input  sum, cout, prop, gen, sum_q, cout_q, out_valid, carry_cnt, err_q
    );

    modport slave (
        input  a, b, cin, in_valid,
        output sum, cout, prop, gen, sum_q, cout_q, out_valid, carry_cnt, err_q
    );

endinterface

// File: rtl/full_adder_fa_cell.sv
// Purely combinational 1-bit full adder cell with propagate/generate terms.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout,
    output logic prop,
    output logic gen
);

    assign prop = a ^ b;
    assign gen  = a & b;
    assign sum  = prop ^ cin;
    assign cout = gen | (cin & prop);

endmodule

// File: rtl/full_adder.sv
// Full adder with registered result, saturating carry-event counter and an
// optional redundant truth-table checker enabled by FULL_ADDER_CHECK_EN.
module full_adder
    import full_adder_pkg::*;
    #(parameter int CNT_W = CNT_W_DEFAULT) (
    input  logic         clk,
    input  logic         rst,
    full_adder_if.slave  fa
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             c_sum;
    logic             c_cout;
    logic             c_prop;
    logic             c_gen;
    logic             sum_p1;
    logic             cout_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             err_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    fa_cell u_cell (
        .a    (fa.a),
        .b    (fa.b),
        .cin  (fa.cin),
        .sum  (c_sum),
        .cout (c_cout),
        .prop (c_prop),
        .gen  (c_gen)
    );

    assign fa.sum  = c_sum;
    assign fa.cout = c_cout;
    assign fa.prop = c_prop;
    assign fa.gen  = c_gen;

    // p0 -> p1: capture qualified result and count carry events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p1  <= 1'b0;
            cout_p1 <= 1'b0;
            vld_p1  <= 1'b0;
            cnt_p1  <= '0;
        end else begin
            vld_p1 <= fa.in_valid;
            if (fa.in_valid) begin
                sum_p1  <= c_sum;
                cout_p1 <= c_cout;
                if (c_cout) begin
                    cnt_p1 <= sat_inc(cnt_p1);
                end
            end
        end
    end

`ifdef FULL_ADDER_CHECK_EN
    fa_result_t ref_r;
    logic       mis;

    assign ref_r = fa_lookup({fa.a, fa.b, fa.cin});
    assign mis   = (ref_r.sum != c_sum) || (ref_r.cout != c_cout);

    // Sticky: only reset clears a detected disagreement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_p1 <= 1'b0;
        end else if (fa.in_valid && mis) begin
            err_p1 <= 1'b1;
        end
    end
`else
    assign err_p1 = 1'b0;
`endif

    assign fa.sum_q     = sum_p1;
    assign fa.cout_q    = cout_p1;
    assign fa.out_valid = vld_p1;
    assign fa.carry_cnt = cnt_p1;
    assign fa.err_q     = err_p1;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: directed vectors, an 8-bit and a 2-bit
// counter instance sharing stimulus; checker fault test under FULL_ADDER_CHECK_EN.
module tb_full_adder;

    typedef struct {
        logic       vld;
        logic       s;
        logic       c;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b1;

    exp_t       q[$];
    exp_t       e;
    logic [7:0] m_cnt = '0;
    logic [1:0] m_cnt2 = '0;
    logic       h_s = 1'b0;
    logic       h_c = 1'b0;
    logic [7:0] h_cnt = '0;
    logic [1:0] h_cnt2 = '0;

    // Hand-written {sum,cout} for {a,b,cin} = 0..7
    logic [1:0] tt [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    full_adder_if #(.CNT_W(8)) fa ();
    full_adder_if #(.CNT_W(2)) fa2 ();

    assign fa2.a        = fa.a;
    assign fa2.b        = fa.b;
    assign fa2.cin      = fa.cin;
    assign fa2.in_valid = fa.in_valid;

    full_adder #(.CNT_W(8)) dut  (.clk(clk), .rst(rst), .fa(fa));
    full_adder #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .fa(fa2));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic va, input logic vb, input logic vc, input logic vv);
        logic [2:0] idx;
        @(posedge clk);
        #1;
        fa.a = va; fa.b = vb; fa.cin = vc; fa.in_valid = vv;
        idx = {va, vb, vc};
        if (vv && tt[idx][0]) begin
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
        end
        q.push_back('{vld: vv, s: tt[idx][1], c: tt[idx][0], cnt: m_cnt, cnt2: m_cnt2, cyc: cyc});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        fa.in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        m_cnt = '0;
        m_cnt2 = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                h_s = 1'b0; h_c = 1'b0; h_cnt = '0; h_cnt2 = '0;
                chk("rst_out_valid", int'(fa.out_valid), 0);
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("out_valid", int'(fa.out_valid), int'(e.vld));
                if (e.vld) begin
                    h_s = e.s;
                    h_c = e.c;
                end
                h_cnt = e.cnt;
                h_cnt2 = e.cnt2;
            end else begin
                chk("idle_out_valid", int'(fa.out_valid), 0);
            end
            chk("sum_q", int'(fa.sum_q), int'(h_s));
            chk("cout_q", int'(fa.cout_q), int'(h_c));
            chk("carry_cnt", int'(fa.carry_cnt), int'(h_cnt));
            chk("carry_cnt_w2", int'(fa2.carry_cnt), int'(h_cnt2));
            chk("err_q", int'(fa.err_q), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fa.a = 1'b0; fa.b = 1'b0; fa.cin = 1'b0; fa.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_sum_q", int'(fa.sum_q), 0);
        chk("reset_cout_q", int'(fa.cout_q), 0);
        chk("reset_out_valid", int'(fa.out_valid), 0);
        chk("reset_carry_cnt", int'(fa.carry_cnt), 0);
        chk("reset_err_q", int'(fa.err_q), 0);

        // Combinational sweep while held in reset
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            fa.a = v[2]; fa.b = v[1]; fa.cin = v[0];
            #10;
            chk("comb_sum", int'(fa.sum), int'(tt[i][1]));
            chk("comb_cout", int'(fa.cout), int'(tt[i][0]));
            chk("comb_prop", int'(fa.prop), int'(v[2] ^ v[1]));
            chk("comb_gen", int'(fa.gen), int'(v[2] & v[1]));
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Registered load, then hold with in_valid low
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_sum_q", int'(fa.sum_q), 0);
        chk("hold_cout_q", int'(fa.cout_q), 1);

        // Ten carry vectors: 8-bit counter reaches 10, 2-bit saturates at 3
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("cnt_ten", int'(fa.carry_cnt), 10);
        chk("cnt_sat_w2", int'(fa2.carry_cnt), 3);

        // Asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        chk("pre_rst_out_valid", int'(fa.out_valid), 1);
        chk("pre_rst_cnt", int'(fa.carry_cnt), 4);
        rst = 1'b1;
        #1;
        chk("async_sum_q", int'(fa.sum_q), 0);
        chk("async_cout_q", int'(fa.cout_q), 0);
        chk("async_out_valid", int'(fa.out_valid), 0);
        chk("async_cnt", int'(fa.carry_cnt), 0);
        chk("async_err_q", int'(fa.err_q), 0);
        chk("async_comb_sum", int'(fa.sum), 1);
        chk("async_comb_cout", int'(fa.cout), 1);
        fa.a = 1'b0; fa.b = 1'b1; fa.cin = 1'b0; fa.in_valid = 1'b0;
        #1;
        chk("async_comb_sum2", int'(fa.sum), 1);
        chk("async_comb_cout2", int'(fa.cout), 0);
        q.delete();
        m_cnt = '0;
        m_cnt2 = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back sweep of every vector with in_valid high
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            step(v[2], v[1], v[0], 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sweep_cnt", int'(fa.carry_cnt), 4);

`ifdef FULL_ADDER_CHECK_EN
        // Corrupt the primary sum and expect the checker to latch
        mon_en = 1'b0;
        force dut.c_sum = ~(fa.a ^ fa.b ^ fa.cin);
        @(posedge clk);
        #1;
        fa.a = 1'b0; fa.b = 1'b0; fa.cin = 1'b0; fa.in_valid = 1'b1;
        @(posedge clk);
        #1;
        fa.in_valid = 1'b0;
        release dut.c_sum;
        chk("chk_err_set", int'(fa.err_q), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("chk_err_sticky", int'(fa.err_q), 1);
        rst = 1'b1;
        #1;
        chk("chk_err_cleared", int'(fa.err_q), 0);
        q.delete();
        m_cnt = '0;
        m_cnt2 = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
